multicycle_control_unit: RTL and testbench

- Main-control FSM of the multicycle CPU.
- Sequences each instruction through IF/ID/EXE/MEM/WB states and decodes Opcode into datapath controls.
- Drives the 2-bit RegDst select of the downstream 5-bit three-way write-register selector: 00 = $31, 01 = rt, 10 = rd.
- Also drives the PC, IR, register file, ALU and data memory enables.

---
 rtl/multicycle_control_unit.sv | 276 +++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Main-control FSM of the multicycle CPU: IF/ID/EXE/MEM/WB sequencing.
// Optional macro ILLEGAL_OP_TRAP_EN traps unknown opcodes in ID.
module multicycle_control_unit #(
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  output logic [2:0] State,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegData,
  output logic       DBDataSrc,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       MemRd,
  output logic       MemWr,
  output logic [1:0] PCSrc,
  output logic       IllegalOp
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTIU = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;

  state_t r_state;
  state_t w_next;

  logic       w_rtype;
  logic       w_imm;
  logic       w_alu;
  logic       w_ls;
  logic       w_lw;
  logic       w_beq;
  logic       w_j;
  logic       w_jr;
  logic       w_jal;
  logic       w_halt;
  logic       w_known;
  logic [2:0] w_alu_op;
  logic       w_alu_a;
  logic       w_alu_b;
  logic       w_alu_ext;

  logic       w_pcwre;
  logic       w_irwre;
  logic       w_regwre;
  logic [1:0] w_regdst;
  logic       w_wrregdata;
  logic       w_dbdatasrc;
  logic       w_alusrca;
  logic       w_alusrcb;
  logic [2:0] w_aluop;
  logic       w_extsel;
  logic       w_memrd;
  logic       w_memwr;
  logic [1:0] w_pcsrc;
  logic       w_illegal;

  assign w_rtype = (Opcode == OP_ADD) || (Opcode == OP_SUB) ||
                   (Opcode == OP_OR)  || (Opcode == OP_AND) ||
                   (Opcode == OP_SLL) || (Opcode == OP_SLT);
  assign w_imm   = (Opcode == OP_ADDI) || (Opcode == OP_ORI) ||
                   (Opcode == OP_SLTIU);
  assign w_alu   = w_rtype || w_imm;
  assign w_lw    = (Opcode == OP_LW);
  assign w_ls    = w_lw || (Opcode == OP_SW);
  assign w_beq   = (Opcode == OP_BEQ);
  assign w_j     = (Opcode == OP_J);
  assign w_jr    = (Opcode == OP_JR);
  assign w_jal   = (Opcode == OP_JAL);
  assign w_halt  = (Opcode == HALT_OPCODE);
  assign w_known = w_halt || w_alu || w_ls || w_beq ||
                   w_j || w_jr || w_jal;

  // ALU controls shared by EXE_AL and WB_AL
  always_comb begin
    w_alu_op  = 3'b000;
    w_alu_a   = 1'b0;
    w_alu_b   = w_imm;
    w_alu_ext = 1'b1;
    case (Opcode)
      OP_SUB:   w_alu_op = 3'b001;
      OP_OR:    w_alu_op = 3'b010;
      OP_ORI: begin
        w_alu_op  = 3'b010;
        w_alu_ext = 1'b0;
      end
      OP_AND:   w_alu_op = 3'b011;
      OP_SLL: begin
        w_alu_op = 3'b100;
        w_alu_a  = 1'b1;
      end
      OP_SLT:   w_alu_op = 3'b101;
      OP_SLTIU: begin
        w_alu_op  = 3'b101;
        w_alu_ext = 1'b0;
      end
      default:  w_alu_op = 3'b000;
    endcase
  end

  // State register; reset returns to IF
  always_ff @(posedge CLK) begin
    if (Reset) r_state <= S_IF;
    else       r_state <= w_next;
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic r_illegal;

  // Sticky trap flag, cleared only by reset
  always_ff @(posedge CLK) begin
    if (Reset)
      r_illegal <= 1'b0;
    else if (r_state == S_ID && !w_known)
      r_illegal <= 1'b1;
  end

  assign w_illegal = r_illegal ||
                     (r_state == S_ID && !w_known);
`else
  assign w_illegal = 1'b0;
`endif

  // Next-state and datapath control decode
  always_comb begin
    w_next      = r_state;
    w_pcwre     = 1'b0;
    w_irwre     = 1'b0;
    w_regwre    = 1'b0;
    w_regdst    = 2'b00;
    w_wrregdata = 1'b0;
    w_dbdatasrc = 1'b0;
    w_alusrca   = 1'b0;
    w_alusrcb   = 1'b0;
    w_aluop     = 3'b000;
    w_extsel    = 1'b0;
    w_memrd     = 1'b0;
    w_memwr     = 1'b0;
    w_pcsrc     = 2'b00;
    case (r_state)
      S_IF: begin
        w_irwre = 1'b1;
        w_next  = S_ID;
      end
      S_ID: begin
        unique case (1'b1)
          w_halt: w_next = S_ID;
          w_alu:  w_next = S_EXE_AL;
          w_ls:   w_next = S_EXE_LS;
          w_beq:  w_next = S_EXE_BR;
          w_j: begin
            w_next  = S_IF;
            w_pcwre = 1'b1;
            w_pcsrc = 2'b11;
          end
          w_jr: begin
            w_next  = S_IF;
            w_pcwre = 1'b1;
            w_pcsrc = 2'b10;
          end
          w_jal: begin
            w_next   = S_IF;
            w_pcwre  = 1'b1;
            w_pcsrc  = 2'b11;
            w_regwre = 1'b1;
          end
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            w_next  = S_ID;
`else
            w_next  = S_IF;
            w_pcwre = 1'b1;
`endif
          end
        endcase
      end
      S_EXE_AL, S_WB_AL: begin
        w_aluop   = w_alu_op;
        w_alusrca = w_alu_a;
        w_alusrcb = w_alu_b;
        w_extsel  = w_alu_ext;
        if (r_state == S_EXE_AL) begin
          w_next = S_WB_AL;
        end else begin
          w_next      = S_IF;
          w_regwre    = 1'b1;
          w_wrregdata = 1'b1;
          w_pcwre     = 1'b1;
          w_regdst    = w_rtype ? 2'b10 : 2'b01;
        end
      end
      S_EXE_LS: begin
        w_alusrcb = 1'b1;
        w_extsel  = 1'b1;
        w_next    = S_MEM;
      end
      S_MEM: begin
        w_alusrcb = 1'b1;
        w_extsel  = 1'b1;
        if (w_lw) begin
          w_memrd = 1'b1;
          w_next  = S_WB_LD;
        end else begin
          w_memwr = 1'b1;
          w_pcwre = 1'b1;
          w_next  = S_IF;
        end
      end
      S_WB_LD: begin
        w_alusrcb   = 1'b1;
        w_extsel    = 1'b1;
        w_memrd     = 1'b1;
        w_dbdatasrc = 1'b1;
        w_wrregdata = 1'b1;
        w_regwre    = 1'b1;
        w_regdst    = 2'b01;
        w_pcwre     = 1'b1;
        w_next      = S_IF;
      end
      S_EXE_BR: begin
        w_aluop = 3'b001;
        w_pcwre = 1'b1;
        w_pcsrc = Zero ? 2'b01 : 2'b00;
        w_next  = S_IF;
      end
      default: w_next = S_IF;
    endcase
  end

  assign State     = Reset ? 3'b000 : r_state;
  assign PCWre     = !Reset && w_pcwre;
  assign IRWre     = !Reset && w_irwre;
  assign RegWre    = !Reset && w_regwre;
  assign RegDst    = Reset ? 2'b00 : w_regdst;
  assign WrRegData = !Reset && w_wrregdata;
  assign DBDataSrc = !Reset && w_dbdatasrc;
  assign ALUSrcA   = !Reset && w_alusrca;
  assign ALUSrcB   = !Reset && w_alusrcb;
  assign ALUOp     = Reset ? 3'b000 : w_aluop;
  assign ExtSel    = !Reset && w_extsel;
  assign MemRd     = !Reset && w_memrd;
  assign MemWr     = !Reset && w_memwr;
  assign PCSrc     = Reset ? 2'b00 : w_pcsrc;
  assign IllegalOp = !Reset && w_illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
// Instruction-level reference model; honours ILLEGAL_OP_TRAP_EN.
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] Opcode;
  logic       Zero;
  logic [2:0] State;
  logic       PCWre, IRWre, RegWre;
  logic [1:0] RegDst;
  logic       WrRegData, DBDataSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp;
  logic       ExtSel, MemRd, MemWr;
  logic [1:0] PCSrc;
  logic       IllegalOp;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  multicycle_control_unit dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
    .State(State), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
    .RegDst(RegDst), .WrRegData(WrRegData), .DBDataSrc(DBDataSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ExtSel(ExtSel), .MemRd(MemRd), .MemWr(MemWr), .PCSrc(PCSrc),
    .IllegalOp(IllegalOp)
  );

  logic [20:0] obs;
  assign obs = {State, PCWre, IRWre, RegWre, RegDst, WrRegData,
                DBDataSrc, ALUSrcA, ALUSrcB, ALUOp, ExtSel, MemRd,
                MemWr, PCSrc, IllegalOp};

  logic [5:0] known [16] = '{
    6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
    6'b010010, 6'b011000, 6'b100110, 6'b100111, 6'b110000,
    6'b110001, 6'b110100, 6'b111000, 6'b111001, 6'b111010,
    6'b111111};

  // ALU-instruction table: returns 1 if op is an ALU instruction
  function automatic bit alu_info(input logic [5:0] op,
      output logic [2:0] aop, output logic sa, output logic sb,
      output logic ext, output logic rt);
    sa = 0; sb = 0; ext = 1; rt = 1; aop = 0;
    case (op)
      6'b000000: aop = 3'd0;
      6'b000001: aop = 3'd1;
      6'b000010: begin aop = 3'd0; sb = 1; rt = 0; end
      6'b010000: aop = 3'd2;
      6'b010001: aop = 3'd3;
      6'b010010: begin aop = 3'd2; sb = 1; ext = 0; rt = 0; end
      6'b011000: begin aop = 3'd4; sa = 1; end
      6'b100110: aop = 3'd5;
      6'b100111: begin aop = 3'd5; sb = 1; ext = 0; rt = 0; end
      default: return 0;
    endcase
    return 1;
  endfunction

  function automatic bit is_known(input logic [5:0] op);
    foreach (known[i]) if (known[i] == op) return 1;
    return 0;
  endfunction

  // Cycles from this IF to the next IF (traps are run for 11)
  function automatic int lat(input logic [5:0] op);
    logic [2:0] a; logic x1, x2, x3, x4;
    if (alu_info(op, a, x1, x2, x3, x4)) return 4;
    case (op)
      6'b110001: return 5;
      6'b110000: return 4;
      6'b110100: return 3;
      6'b111000, 6'b111001, 6'b111010: return 2;
      6'b111111: return 11;
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        return 11;
`else
        return 2;
`endif
      end
    endcase
  endfunction

  // Expected output vector for cycle k of an instruction
  function automatic logic [20:0] model(input logic [5:0] op,
      input logic z, input int k);
    logic [2:0] st, aop, a_op;
    logic pcw, irw, rw, wrd, dbs, sa, sb, ext, mrd, mwr, ill;
    logic [1:0] rd, pcs;
    logic a_sa, a_sb, a_ext, a_rt;
    st = 0; aop = 0; pcw = 0; irw = 0; rw = 0; wrd = 0; dbs = 0;
    sa = 0; sb = 0; ext = 0; mrd = 0; mwr = 0; ill = 0;
    rd = 0; pcs = 0;
    if (k == 0) begin
      irw = 1;
    end else if (k == 1) begin
      st = 3'd1;
      case (op)
        6'b111000: begin pcw = 1; pcs = 2'b11; end
        6'b111001: begin pcw = 1; pcs = 2'b10; end
        6'b111010: begin pcw = 1; pcs = 2'b11; rw = 1; end
        default: if (!is_known(op)) begin
`ifdef ILLEGAL_OP_TRAP_EN
          ill = 1;
`else
          pcw = 1;
`endif
        end
      endcase
    end else if (alu_info(op, a_op, a_sa, a_sb, a_ext, a_rt)) begin
      st = (k == 2) ? 3'd6 : 3'd7;
      aop = a_op; sa = a_sa; sb = a_sb; ext = a_ext;
      if (k == 3) begin
        rw = 1; wrd = 1; pcw = 1;
        rd = a_rt ? 2'b10 : 2'b01;
      end
    end else if (op == 6'b110001 || op == 6'b110000) begin
      st = 3'(k);
      sb = 1; ext = 1;
      if (k == 3 && op == 6'b110001) mrd = 1;
      if (k == 3 && op == 6'b110000) begin mwr = 1; pcw = 1; end
      if (k == 4) begin
        mrd = 1; dbs = 1; wrd = 1; rw = 1; rd = 2'b01; pcw = 1;
      end
    end else if (op == 6'b110100) begin
      st = 3'd5; aop = 3'd1; pcw = 1;
      pcs = z ? 2'b01 : 2'b00;
    end else begin
      st = 3'd1;
`ifdef ILLEGAL_OP_TRAP_EN
      ill = !is_known(op);
`endif
    end
    return {st, pcw, irw, rw, rd, wrd, dbs, sa, sb, aop, ext,
            mrd, mwr, pcs, ill};
  endfunction

  function automatic logic [5:0] rand_unknown();
    logic [5:0] op;
    do op = 6'($urandom_range(0, 63)); while (is_known(op));
    return op;
  endfunction

  task automatic pulse_reset();
    Reset = 1;
    @(negedge CLK);
    Reset = 0;
  endtask

  task automatic test_reset();
    logic [20:0] e;
    Reset = 1; Opcode = 0; Zero = 0;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (obs !== 21'd0) begin
      failures++;
      $display("FAIL reset_init got=%h exp=%h", obs, 21'd0);
    end
    Reset = 0;
    for (int k = 0; k < 3; k++) begin
      Opcode = 6'b000000; #1;
      e = model(Opcode, Zero, k);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_pre k=%0d got=%h exp=%h", k, obs, e);
      end
      @(negedge CLK);
    end
    Reset = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (obs !== 21'd0 || RegWre !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold k=%0d got=%h exp=%h", k, obs, 21'd0);
      end
      @(negedge CLK);
    end
    Reset = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      e = model(Opcode, Zero, k);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_post k=%0d got=%h exp=%h", k, obs, e);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_alu(input int n);
    logic [20:0] e;
    for (int i = 0; i < n; i++) begin
      logic [5:0] op;
      op = known[$urandom_range(0, 8)];
      for (int k = 0; k < lat(op); k++) begin
        Opcode = op; Zero = 1'($urandom); #1;
        e = model(op, Zero, k);
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL alu op=%b k=%0d got=%h exp=%h", op, k, obs, e);
        end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_load_store();
    logic [20:0] e;
    logic [5:0] ops [2];
    ops[0] = 6'b110001; ops[1] = 6'b110000;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < lat(ops[i]); k++) begin
        Opcode = ops[i]; Zero = 1'($urandom); #1;
        e = model(ops[i], Zero, k);
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL ldst op=%b k=%0d got=%h exp=%h",
                   ops[i], k, obs, e);
        end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_branch();
    logic [20:0] e;
    for (int i = 0; i < 4; i++) begin
      logic z;
      z = 1'(i & 1);
      for (int k = 0; k < 3; k++) begin
        Opcode = 6'b110100; Zero = (k == 2) ? z : ~z; #1;
        e = model(Opcode, Zero, k);
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL beq z=%0b k=%0d got=%h exp=%h", z, k, obs, e);
        end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_jumps();
    logic [20:0] e;
    for (int i = 12; i < 15; i++) begin
      for (int k = 0; k < 2; k++) begin
        Opcode = known[i]; Zero = 1'($urandom); #1;
        e = model(Opcode, Zero, k);
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL jump op=%b k=%0d got=%h exp=%h",
                   Opcode, k, obs, e);
        end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_halt();
    logic [20:0] e;
    for (int k = 0; k < 11; k++) begin
      Opcode = 6'b111111; Zero = 1'($urandom); #1;
      e = model(Opcode, Zero, k);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL halt k=%0d got=%h exp=%h", k, obs, e);
      end
      @(negedge CLK);
    end
    pulse_reset();
  endtask

  task automatic test_unknown();
    logic [20:0] e;
    logic [5:0] op;
    for (int i = 0; i < 3; i++) begin
      op = (i == 0) ? 6'b101010 : rand_unknown();
      for (int k = 0; k < lat(op); k++) begin
        Opcode = op; Zero = 1'($urandom); #1;
        e = model(op, Zero, k);
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL unknown op=%b k=%0d got=%h exp=%h",
                   op, k, obs, e);
        end
        @(negedge CLK);
      end
`ifdef ILLEGAL_OP_TRAP_EN
      pulse_reset();
`endif
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [20:0] e;
    logic [5:0] op;
    for (int i = 0; i < n; i++) begin
      op = known[$urandom_range(0, 14)];
      for (int k = 0; k < lat(op); k++) begin
        Opcode = op; Zero = 1'($urandom); #1;
        e = model(op, Zero, k);
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL b2b i=%0d op=%b k=%0d got=%h exp=%h",
                   i, op, k, obs, e);
        end
        @(negedge CLK);
      end
    end
  endtask

  initial begin
    Reset = 1; Opcode = 0; Zero = 0;
    @(negedge CLK);
    test_reset();
    test_alu(20);
    test_load_store();
    test_branch();
    test_jumps();
    test_halt();
    test_unknown();
    test_back_to_back(60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
